// File: rtl/sdm_tx_sched.sv
// sdm_tx_sched: round-robin scheduler sharing one sdm_tx between four sample requesters, inserting idle code on underflow.
module sdm_tx_sched #(
  parameter int NREQ = 4,
  parameter int TMO  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setn,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  input  logic              tx_empty,
  output logic              tx_push,
  output logic              tx_clear,
  output logic [3:0]        tx_wdata,
  output logic [1:0]        grant_id,
  output logic [7:0]        underflow_cnt,
  output logic              err,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ARB, PUSH, WAITLO, WAITHI, CLR} state_t;
  state_t state, nxt;
  logic [7:0] tcnt;
  logic [1:0] win, idx;
  logic hit, tmo_hit;
  // Walk from lowest to highest priority so the last hit is the first requester after grant_id.
  always_comb begin
    win = grant_id;
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = grant_id + 2'(k);
      if (req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  assign tmo_hit = tx_empty && (tcnt + 8'd1 == 8'(TMO));
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (en && tx_empty) ? ARB : IDLE;
      ARB:     nxt = PUSH;
      PUSH:    nxt = WAITLO;
      WAITLO:  nxt = !tx_empty ? WAITHI : tmo_hit ? ARB : WAITLO;
      WAITHI:  nxt = !tx_empty ? WAITHI : en ? ARB : CLR;
      CLR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // A frozen cycle holds the FSM, so a pulse due then is issued on the first enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ack           <= '0;
      tx_push       <= 1'b0;
      tx_clear      <= 1'b0;
      tx_wdata      <= '0;
      grant_id      <= 2'd3;
      underflow_cnt <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      tcnt          <= '0;
    end else if (!setn) begin
      ack      <= '0;
      tx_push  <= 1'b0;
      tx_clear <= 1'b0;
    end else begin
      state    <= nxt;
      busy     <= nxt != IDLE;
      tx_push  <= state == ARB;
      tx_clear <= nxt == CLR;
      ack      <= (state == ARB && hit) ? NREQ'(1) << win : '0;
      tcnt     <= (state == WAITLO) ? tcnt + 8'd1 : '0;
      if (state == ARB) begin
        tx_wdata <= hit ? req_data[4*win +: 4] : 4'd0;
        if (hit) grant_id <= win;
        else if (underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 8'd1;
      end
      if (state == WAITLO && tmo_hit) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdm_tx_sched.sv
// tb_sdm_tx_sched: randomized frames against a round-robin reference model, plus freeze, disable and timeout scenarios.
module tb_sdm_tx_sched;
  logic clk = 0, rst = 1, setn = 1, en = 0, tx_empty = 1;
  logic [3:0] req = '0;
  logic [15:0] req_data = '0;
  logic [3:0] ack, tx_wdata;
  logic tx_push, tx_clear, err, busy;
  logic [1:0] grant_id;
  logic [7:0] underflow_cnt;
  int n_cmp = 0, n_bad = 0;
  int fall = 0, rise = 0, stray = 0, pushes = 0, clears = 0;
  int m_grant = 3, m_uf = 0;
  bit stuck = 0;

  always #5 clk = ~clk;

  sdm_tx_sched dut (
    .clk(clk), .rst(rst), .setn(setn), .en(en), .req(req), .req_data(req_data),
    .ack(ack), .tx_empty(tx_empty), .tx_push(tx_push), .tx_clear(tx_clear),
    .tx_wdata(tx_wdata), .grant_id(grant_id), .underflow_cnt(underflow_cnt),
    .err(err), .busy(busy)
  );

  function automatic int exp_win(input int last, input logic [3:0] r);
    for (int d = 1; d <= 4; d++) if (r[(last + d) % 4]) return (last + d) % 4;
    return -1;
  endfunction

  // One clock, with a behavioural sdm_tx: empty falls 2 cycles after a push, rises 20 later.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (ack !== 4'd0 && tx_push !== 1'b1) stray++;
    if (tx_push === 1'b1) pushes++;
    if (tx_clear === 1'b1) clears++;
    if (fall > 0) begin
      fall--;
      if (fall == 0) begin
        tx_empty = 0;
        rise = 20;
      end
    end else if (rise > 0) begin
      rise--;
      if (rise == 0) tx_empty = 1;
    end
    if (tx_push === 1'b1 && !stuck) fall = 2;
  endtask

  task automatic frame(input logic [3:0] r, output logic got, output logic [3:0] w, output logic [3:0] a,
                       output logic [1:0] g, output logic [15:0] d);
    d = 16'($urandom);
    req = r;
    req_data = d;
    got = 0; w = 0; a = 0; g = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      cyc();
      if (tx_push === 1'b1) begin
        got = 1; w = tx_wdata; a = ack; g = grant_id;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      req = 4'($urandom); req_data = 16'($urandom); en = 1'($urandom);
      setn = 1'($urandom); tx_empty = 1'($urandom);
      cyc();
    end
    n_cmp++; if (ack !== 4'd0) begin n_bad++; $display("FAIL reset ack: got %b want 0000", ack); end
    n_cmp++; if (tx_push !== 1'b0) begin n_bad++; $display("FAIL reset tx_push: got %b want 0", tx_push); end
    n_cmp++; if (tx_clear !== 1'b0) begin n_bad++; $display("FAIL reset tx_clear: got %b want 0", tx_clear); end
    n_cmp++; if (tx_wdata !== 4'd0) begin n_bad++; $display("FAIL reset tx_wdata: got %h want 0", tx_wdata); end
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL reset grant_id: got %0d want 3", grant_id); end
    n_cmp++; if (underflow_cnt !== 8'd0) begin n_bad++; $display("FAIL reset underflow_cnt: got %0d want 0", underflow_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    en = 0; setn = 1; tx_empty = 1; req = '0;
    rst = 0;
    cyc(); cyc();
  endtask

  task automatic test_single();
    logic got; logic [3:0] w, a; logic [1:0] g; logic [15:0] d;
    d = 16'($urandom);
    d[11:8] = 4'b1101;
    req = 4'b0100; req_data = d; en = 1;
    cyc();
    n_cmp++; if (tx_push !== 1'b0) begin n_bad++; $display("FAIL single early push: got %b want 0", tx_push); end
    cyc();
    n_cmp++;
    if (tx_push !== 1'b1 || tx_wdata !== 4'b1101 || ack !== 4'b0100 || grant_id !== 2'd2) begin
      n_bad++;
      $display("FAIL single first push: push=%b wdata=%b ack=%b grant=%0d want 1 1101 0100 2", tx_push, tx_wdata, ack, grant_id);
    end
    m_grant = 2;
    for (int f = 0; f < 3; f++) begin
      frame(4'b0100, got, w, a, g, d);
      n_cmp++;
      if (got !== 1'b1 || w !== d[11:8] || a !== 4'b0100 || g !== 2'd2) begin
        n_bad++;
        $display("FAIL single frame %0d: got=%b wdata=%h ack=%b grant=%0d want wdata=%h ack=0100 grant=2", f, got, w, a, g, d[11:8]);
      end
    end
  endtask

  task automatic test_frames(input string name, input int nf, input int mode);
    logic got; logic [3:0] w, a, r, ew, ea; logic [1:0] g, eg; logic [15:0] d;
    int e, eu;
    for (int f = 0; f < nf; f++) begin
      r = (mode == 0) ? 4'hF : (mode == 1) ? (($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom)) : 4'd0;
      frame(r, got, w, a, g, d);
      e = exp_win(m_grant, r);
      if (e < 0) begin
        ew = 4'd0; ea = 4'd0; eg = 2'(m_grant); m_uf++;
      end else begin
        ew = d[4*e +: 4]; ea = 4'b0001 << e; eg = 2'(e); m_grant = e;
      end
      eu = (m_uf > 255) ? 255 : m_uf;
      n_cmp++;
      if (got !== 1'b1 || w !== ew || a !== ea || g !== eg || underflow_cnt !== 8'(eu)) begin
        n_bad++;
        $display("FAIL %s frame %0d req=%b: got=%b wdata=%h ack=%b grant=%0d ufl=%0d want wdata=%h ack=%b grant=%0d ufl=%0d",
                 name, f, r, got, w, a, g, underflow_cnt, ew, ea, eg, eu);
      end
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL %s ack without push: got %0d want 0", name, stray); end
  endtask

  task automatic test_disable();
    logic got; logic [3:0] w, a; logic [1:0] g; logic [15:0] d;
    int c0, p0;
    frame(4'hF, got, w, a, g, d);
    m_grant = exp_win(m_grant, 4'hF);
    cyc();
    en = 0;
    c0 = clears; p0 = pushes;
    for (int i = 0; i < 100 && busy === 1'b1; i++) cyc();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL disable busy: got %b want 0", busy); end
    n_cmp++; if (clears - c0 !== 1) begin n_bad++; $display("FAIL disable clear pulses: got %0d want 1", clears - c0); end
    n_cmp++; if (pushes - p0 !== 0) begin n_bad++; $display("FAIL disable extra pushes: got %0d want 0", pushes - p0); end
    cyc(); cyc();
    n_cmp++; if (clears - c0 !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL disable idle: clears=%0d busy=%b want 1 0", clears - c0, busy); end
  endtask

  task automatic test_freeze();
    logic [15:0] d;
    int p0, bad, e;
    d = 16'($urandom);
    req = 4'b0010; req_data = d; en = 1;
    e = exp_win(m_grant, 4'b0010);
    p0 = pushes;
    cyc();
    setn = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (tx_push !== 1'b0 || ack !== 4'd0 || grant_id !== 2'(m_grant)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL freeze hold: got %0d bad cycles want 0", bad); end
    setn = 1;
    cyc();
    n_cmp++;
    if (tx_push !== 1'b1 || ack !== 4'b0010 || tx_wdata !== d[7:4] || grant_id !== 2'(e)) begin
      n_bad++;
      $display("FAIL freeze delayed push: push=%b ack=%b wdata=%h grant=%0d want 1 0010 %h %0d", tx_push, ack, tx_wdata, grant_id, d[7:4], e);
    end
    m_grant = e;
    setn = 0;
    cyc();
    n_cmp++; if (tx_push !== 1'b0 || ack !== 4'd0) begin n_bad++; $display("FAIL freeze in push: push=%b ack=%b want 0 0000", tx_push, ack); end
    cyc();
    setn = 1;
    cyc(); cyc();
    n_cmp++; if (pushes - p0 !== 1) begin n_bad++; $display("FAIL freeze pulse count: got %0d want 1", pushes - p0); end
  endtask

  task automatic test_timeout();
    logic got; logic [3:0] w, a; logic [1:0] g; logic [15:0] d;
    int first = -1, pk = -1;
    for (int i = 0; i < 100 && (tx_empty !== 1'b1 || fall != 0); i++) cyc();
    stuck = 1;
    frame(4'd0, got, w, a, g, d);
    n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL timeout setup: got=%b err=%b want 1 0", got, err); end
    for (int k = 1; k <= 45 && pk < 0; k++) begin
      cyc();
      if (err === 1'b1 && first < 0) first = k;
      if (tx_push === 1'b1) pk = k;
    end
    n_cmp++; if (first < 31 || first > 33) begin n_bad++; $display("FAIL timeout err cycle: got %0d want 31..33", first); end
    n_cmp++; if (pk <= first) begin n_bad++; $display("FAIL timeout next push: got cycle %0d want after %0d", pk, first); end
    cyc();
    rst = 1; en = 0;
    cyc();
    rst = 0;
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0 || grant_id !== 2'd3 || tx_clear !== 1'b0 || tx_push !== 1'b0 || underflow_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL timeout reset: busy=%b err=%b grant=%0d clear=%b push=%b ufl=%0d want 0 0 3 0 0 0",
               busy, err, grant_id, tx_clear, tx_push, underflow_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frames("round_robin", 5, 0);
    test_frames("random", 30, 1);
    test_frames("underflow", 300, 2);
    test_disable();
    test_freeze();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
